// File: rtl/lidar_proximity_rx_if.sv
// Signal bundle between three LIDAR PWM echo lines and the proximity receiver.
// master drives the echoes; slave is the receiver that reports near/fault.
interface lidar_proximity_rx_if;
    logic [2:0] pwm_in;
    logic [2:0] near;
    logic [2:0] fault;
    logic [2:0] meas_valid;

    modport master (
        output pwm_in,
        input  near,
        input  fault,
        input  meas_valid
    );

    modport slave (
        input  pwm_in,
        output near,
        output fault,
        output meas_valid
    );
endinterface

// File: rtl/lidar_proximity_rx.sv
// Three-channel LIDAR PWM pulse-width receiver with hysteresis, debounce
// and a fail-safe "near" warning when a sensor goes silent.
module lidar_proximity_rx #(
    parameter int CNT_W     = 16,
    parameter int NEAR_TH   = 3000,
    parameter int HYST      = 200,
    parameter int DEB       = 2,
    parameter int MAX_HIGH  = 50000,
    parameter int SILENT_TO = 60000
) (
    input  logic                 clk,
    input  logic                 rst,
    lidar_proximity_rx_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        WAIT_LOW
    } state_e;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TH_LO = CNT_W'(NEAR_TH);
    localparam logic [CNT_W-1:0] TH_HI = CNT_W'(NEAR_TH + HYST);
    localparam logic [CNT_W-1:0] MAXH  = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] SIL   = CNT_W'(SILENT_TO);
    localparam logic [2:0]       DEB_N = 3'(DEB);

    // fill_q[1] marks that the synchronized sample holds a real input value
    logic [1:0] fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ch
        state_e           st_q;
        logic             s1_q;
        logic             s_q;
        logic             sd_q;
        logic             armed_q;
        logic [CNT_W-1:0] wid_q;
        logic [CNT_W-1:0] sil_q;
        logic [2:0]       deb_q;
        logic             near_q;
        logic             fault_q;
        logic             mv_q;

        logic             rise;
        logic             fall;
        logic             done;
        logic             opp;
        logic             sil_hit;
        logic [CNT_W-1:0] width;
        logic [CNT_W-1:0] sil_d;

        // a rise only counts once a genuine low has been seen since reset
        assign rise  = s_q & ~sd_q & armed_q;
        assign fall  = ~s_q & sd_q;
        assign done  = (st_q == HIGH) && (fall || (wid_q == MAXH - ONE));
        assign width = fall ? wid_q : MAXH;
        assign opp   = near_q ? (width > TH_HI) : (width < TH_LO);

        assign sil_d = rise ? '0
                     : (sil_q == SIL) ? sil_q
                     : sil_q + ONE;
        assign sil_hit = (sil_d == SIL) && (sil_q != SIL);

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q    <= IDLE;
                s1_q    <= 1'b0;
                s_q     <= 1'b0;
                sd_q    <= 1'b0;
                armed_q <= 1'b0;
                wid_q   <= '0;
                sil_q   <= '0;
                deb_q   <= '0;
                near_q  <= 1'b0;
                fault_q <= 1'b0;
                mv_q    <= 1'b0;
            end else begin
                s1_q  <= bus.pwm_in[g];
                s_q   <= s1_q;
                sd_q  <= s_q;
                sil_q <= sil_d;
                mv_q  <= done;
                if (fill_q[1] && !s_q) begin
                    armed_q <= 1'b1;
                end

                unique case (st_q)
                    IDLE: begin
                        if (rise) begin
                            st_q  <= HIGH;
                            wid_q <= ONE;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            st_q <= IDLE;
                        end else if (wid_q == MAXH - ONE) begin
                            st_q  <= WAIT_LOW;
                            wid_q <= MAXH;
                        end else begin
                            wid_q <= wid_q + ONE;
                        end
                    end
                    WAIT_LOW: begin
                        if (fall) begin
                            st_q <= IDLE;
                        end
                    end
                    default: st_q <= IDLE;
                endcase

                // silence overrides any measurement landing in the same cycle
                if (sil_hit) begin
                    fault_q <= 1'b1;
                    near_q  <= 1'b1;
                    deb_q   <= '0;
                end else if (done) begin
                    fault_q <= 1'b0;
                    if (!opp) begin
                        deb_q <= '0;
                    end else if (deb_q + 3'd1 >= DEB_N) begin
                        near_q <= ~near_q;
                        deb_q  <= '0;
                    end else begin
                        deb_q <= deb_q + 3'd1;
                    end
                end
            end
        end

        assign bus.near[g]       = near_q;
        assign bus.fault[g]      = fault_q;
        assign bus.meas_valid[g] = mv_q;
    end
endmodule

// File: tb/tb_lidar_proximity_rx.sv
// Scoreboard bench for lidar_proximity_rx: drivers push expected verdicts,
// a negedge monitor pops them whenever meas_valid fires.
module tb_lidar_proximity_rx;
    localparam int NEAR_TH   = 100;
    localparam int HYST      = 10;
    localparam int DEB       = 2;
    localparam int MAX_HIGH  = 500;
    localparam int SILENT_TO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pwm = '0;
    int         cyc = 0;
    int         rel_cyc = 0;
    int         checks = 0;
    int         errors = 0;

    int         expq[3][$];
    int         mv_seen[3];
    bit         m_near[3];
    int         m_cnt[3];

    lidar_proximity_rx_if bus();
    assign bus.pwm_in = pwm;

    lidar_proximity_rx #(
        .CNT_W(16),
        .NEAR_TH(NEAR_TH),
        .HYST(HYST),
        .DEB(DEB),
        .MAX_HIGH(MAX_HIGH),
        .SILENT_TO(SILENT_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference: classify the pulse, count consecutive opposite verdicts.
    function automatic int model_meas(int ch, int n);
        int w;
        bit want_near;
        bit want_far;
        bit opposite;
        w = (n >= MAX_HIGH) ? MAX_HIGH : n;
        want_near = (w < NEAR_TH);
        want_far  = (w > NEAR_TH + HYST);
        opposite  = m_near[ch] ? want_far : want_near;
        if (opposite) m_cnt[ch] = m_cnt[ch] + 1;
        else m_cnt[ch] = 0;
        if (m_cnt[ch] == DEB) begin
            m_near[ch] = !m_near[ch];
            m_cnt[ch]  = 0;
        end
        return int'(m_near[ch]);
    endfunction

    function automatic void model_clear();
        for (int ch = 0; ch < 3; ch++) begin
            m_near[ch] = 1'b0;
            m_cnt[ch]  = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (bus.meas_valid[ch] === 1'b1) begin
                    mv_seen[ch]++;
                    if (expq[ch].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mv ch%0d: got pulse expected none", ch);
                    end else begin
                        int e;
                        e = expq[ch].pop_front();
                        check($sformatf("meas_ch%0d_fault_near", ch),
                              {30'd0, bus.fault[ch], bus.near[ch]}, e);
                    end
                end
            end
        end
    end

    // Called just after a negedge; holds pwm high for n rising clock edges.
    task automatic pulse(int ch, int n);
        expq[ch].push_back(model_meas(ch, n));
        pwm[ch] = 1'b1;
        repeat (n) @(negedge clk);
        pwm[ch] = 1'b0;
    endtask

    task automatic pulse_off(int ch, int n, int off);
        repeat (off) @(negedge clk);
        pulse(ch, n);
    endtask

    task automatic gap(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        for (int ch = 0; ch < 3; ch++)
            check($sformatf("queue_drained_ch%0d", ch), expq[ch].size(), 0);
        rst = 1'b1;
        pwm = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {23'd0, bus.near, bus.fault, bus.meas_valid}, 0);
        model_clear();
        rst = 1'b0;
        rel_cyc = cyc;
        gap(4);
    endtask

    function automatic int pick_len();
        int b[15];
        b = '{1, 2, 50, 99, 100, 101, 109, 110, 111, 112, 200, 499, 500, 501, 600};
        if ($urandom_range(0, 1) == 1) return b[$urandom_range(0, 14)];
        return int'($urandom_range(1, 300));
    endfunction

    task automatic round();
        int n0, n1, n2, o0, o1, o2;
        n0 = pick_len();
        n1 = pick_len();
        n2 = pick_len();
        o0 = int'($urandom_range(0, 2));
        o1 = int'($urandom_range(0, 2));
        o2 = int'($urandom_range(0, 2));
        fork
            pulse_off(0, n0, o0);
            pulse_off(1, n1, o1);
            pulse_off(2, n2, o2);
        join
        gap(int'($urandom_range(2, 30)));
    endtask

    task automatic wait_mv(string name, int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.meas_valid != 3'b000) begin
                got = 1'b1;
                break;
            end
        end
        check(name, {31'd0, got}, 1);
    endtask

    initial begin
        bit got;
        int seen;
        int c0;

        model_clear();
        for (int ch = 0; ch < 3; ch++) mv_seen[ch] = 0;
        do_reset();

        // two pulse sets on all channels at once
        fork
            pulse(0, 50);
            pulse(1, 50);
            pulse(2, 50);
        join
        wait_mv("sim_mv_seen", 10, got);
        check("sim_mv_all", {29'd0, bus.meas_valid}, 3'b111);
        gap(10);
        fork
            pulse(0, 50);
            pulse(1, 50);
            pulse(2, 50);
        join
        wait_mv("sim_mv2_seen", 10, got);
        check("sim_near_all", {29'd0, bus.near}, 3'b111);
        gap(10);
        do_reset();

        // hold band and debounce on ch1
        pulse(1, 50); gap(10);
        pulse(1, 50); gap(10);
        pulse(1, 105); gap(10);
        pulse(1, 100); gap(10);
        pulse(1, 200); gap(10);
        check("hyst_near1_held", {31'd0, bus.near[1]}, 1);
        pulse(1, 200); gap(10);
        check("hyst_near1_far", {31'd0, bus.near[1]}, 0);
        check("hyst_ch0_ch2_idle", {30'd0, bus.near[2], bus.near[0]}, 0);
        do_reset();

        // high-time saturation on ch2
        seen = mv_seen[2];
        c0 = cyc;
        fork
            pulse(2, 800);
            begin
                wait_mv("sat_mv_seen", 600, got);
                check_range("sat_mv_latency", cyc - c0, 501, 503);
            end
        join
        gap(20);
        check("sat_single_mv", mv_seen[2] - seen, 1);
        do_reset();

        // silence timeout after reset
        got = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (bus.fault != 3'b000) begin
                got = 1'b1;
                break;
            end
        end
        check("silent_fault_seen", {31'd0, got}, 1);
        check_range("silent_latency", cyc - rel_cyc, 999, 1001);
        check("silent_fault_all", {29'd0, bus.fault}, 3'b111);
        check("silent_near_all", {29'd0, bus.near}, 3'b111);
        for (int ch = 0; ch < 3; ch++) begin
            m_near[ch] = 1'b1;
            m_cnt[ch]  = 0;
        end
        pulse(0, 200); gap(10);
        pulse(0, 200); gap(10);
        check("silent_others_faulted", {30'd0, bus.fault[2:1]}, 2'b11);
        do_reset();

        // reset in the middle of a ch1 pulse
        seen = mv_seen[1];
        pwm[1] = 1'b1;
        gap(60);
        rst = 1'b1;
        gap(2);
        check("midrst_outputs", {23'd0, bus.near, bus.fault, bus.meas_valid}, 0);
        model_clear();
        rst = 1'b0;
        gap(88);
        pwm[1] = 1'b0;
        gap(20);
        check("midrst_no_mv", mv_seen[1] - seen, 0);
        pulse(1, 50); gap(10);
        check("midrst_resume_mv", mv_seen[1] - seen, 1);
        do_reset();

        // randomized rounds
        repeat (40) round();
        gap(10);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lidar_proximity_rx.md
LIDAR_PROXIMITY_RX -- requirements
Module: lidar_proximity_rx

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle counters.
REQ-002 SHALL have parameter NEAR_TH, default 3000, pulse width in cycles below which a measurement is "near".
REQ-003 SHALL have parameter HYST, default 200, hysteresis band in cycles above NEAR_TH.
REQ-004 SHALL have parameter DEB, default 2, range 1-7, consecutive equal verdicts required to change near.
REQ-005 SHALL have parameter MAX_HIGH, default 50000, high-time saturation limit in cycles.
REQ-006 SHALL have parameter SILENT_TO, default 60000, cycles without a rising edge before a channel faults.
REQ-007 SHALL have port clk, input, 1 bit, sole clock; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port pwm_in, input, 3 bits, asynchronous LIDAR PWM echo per channel; width proportional to distance.
REQ-010 SHALL have port near, output, 3 bits, registered per-channel obstacle-close flag driving the warning state machine sensor inputs.
REQ-011 SHALL have port fault, output, 3 bits, registered per-channel sensor-silent flag.
REQ-012 SHALL have port meas_valid, output, 3 bits, one-cycle pulse per completed measurement.

Function
REQ-013 SHALL pass each pwm_in bit through a 2-flop synchronizer; all edge detection uses the synchronized signal s and its 1-cycle delayed copy.
REQ-014 SHALL run three identical independent channels; no cross-channel interaction.
REQ-015 Per-channel FSM SHALL have states IDLE, HIGH, WAIT_LOW.
REQ-016 IDLE -> HIGH on rising edge of s; width counter loads 1.
REQ-017 In HIGH, width counter SHALL increment by 1 each cycle s stays high.
REQ-018 HIGH -> IDLE on falling edge of s; captured width = counter value; meas_valid pulses in the cycle after the falling edge is detected.
REQ-019 HIGH -> WAIT_LOW when counter reaches MAX_HIGH with s still high; this SHALL count as a completed "far" measurement with meas_valid pulsed once.
REQ-020 WAIT_LOW -> IDLE on falling edge of s; no meas_valid on that edge.
REQ-021 Verdict SHALL be near if width < NEAR_TH, far if width > NEAR_TH+HYST, hold otherwise; width == NEAR_TH is hold.
REQ-022 A 3-bit debounce counter SHALL increment on each verdict opposite to current near, clear on a verdict equal to near or on hold.
REQ-023 near SHALL toggle and the debounce counter clear in the same cycle as the meas_valid whose verdict brings the count to DEB.
REQ-024 A silence counter SHALL clear on every rising edge of s, otherwise increment, saturating at SILENT_TO.
REQ-025 When the silence counter reaches SILENT_TO, fault SHALL set and near SHALL be forced to 1 (fail-safe warning) in the same cycle.
REQ-026 fault SHALL clear on the next meas_valid; near then follows normal debounce starting from 1 with a cleared count.
REQ-027 Counters SHALL saturate, never wrap; arithmetic unsigned, CNT_W bits.
REQ-028 Rising and falling edges on the same channel within one synchronized cycle SHALL be impossible by construction; simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-029 While rst=1 at a clk edge: near=000, fault=000, meas_valid=000, synchronizers 0, all counters 0, all FSMs IDLE.
REQ-030 Reset asserted mid-measurement SHALL abandon it with no meas_valid; the first measurement after release begins only at a new rising edge seen after release.

Verification
Bench parameters: NEAR_TH=100, HYST=10, DEB=2, MAX_HIGH=500, SILENT_TO=1000.
REQ-031 Two 50-cycle pulses on ch0 -> meas_valid[0] pulses twice; near[0] 0 after first, 1 after second; ch1/ch2 unaffected.
REQ-032 near[1]=1, then pulses of 105 and 100 cycles (hold) then 200 -> near[1] stays 1; only after two consecutive 200-cycle pulses does near[1]=0.
REQ-033 ch2 held high 800 cycles -> single meas_valid[2] at count 500, none at the falling edge; counts as far.
REQ-034 No edges on ch0 for 1000 cycles after reset -> fault[0]=1 and near[0]=1 that cycle; next 200-cycle pulse -> fault[0]=0, near[0] still 1.
REQ-035 rst pulsed at cycle 60 of a 150-cycle ch1 pulse -> all outputs 0, no meas_valid[1] from that pulse.
REQ-036 Simultaneous 50-cycle pulses on all channels -> meas_valid=111 in the same cycle; near=111 after second set.
